// File: rtl/data_mem_unit.sv
// Word-addressed 19-bit data memory with a small request FSM (1-edge write ack, 2-edge read).
// Optional DMEM_CLEAR_ON_RESET_EN: zero the whole array after every reset before serving requests.
module data_mem_unit #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] mem_address,
  input  logic [18:0] mem_data_out,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [18:0] mem_data_in,
  output logic        mem_ready,
  output logic        addr_fault,
  output logic        busy
);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [19:0] DEPTH_W = 20'(DEPTH);

`ifdef DMEM_CLEAR_ON_RESET_EN
  typedef enum logic [2:0] {IDLE, RD, RRESP, WACK, CLR} state_t;
  localparam state_t RST_STATE = CLR;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  logic [AW-1:0] clr_q, clr_d;
`else
  typedef enum logic [2:0] {IDLE, RD, RRESP, WACK} state_t;
  localparam state_t RST_STATE = IDLE;
`endif

  state_t        state_q, state_d;
  logic [18:0]   addr_q, addr_d;
  logic [18:0]   rdata_q, rdata_d;
  logic          fault_q, fault_d;
  logic [18:0]   mem_q [DEPTH];

  logic          we;
  logic [AW-1:0] widx;
  logic [18:0]   wdata;
  logic          req_in_range, lat_in_range;

  // Range checks use the full 19-bit address, so nothing aliases onto the array.
  assign req_in_range = ({1'b0, mem_address} < DEPTH_W);
  assign lat_in_range = ({1'b0, addr_q} < DEPTH_W);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    we      = 1'b0;
    widx    = mem_address[AW-1:0];
    wdata   = mem_data_out;
`ifdef DMEM_CLEAR_ON_RESET_EN
    clr_d   = clr_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_write) begin
          we      = req_in_range;
          fault_d = ~req_in_range;
          state_d = WACK;
        end else if (mem_read) begin
          addr_d  = mem_address;
          state_d = RD;
        end
      end
      RD: begin
        rdata_d = lat_in_range ? mem_q[addr_q[AW-1:0]] : '0;
        fault_d = ~lat_in_range;
        state_d = RRESP;
      end
      RRESP:   state_d = IDLE;
      WACK:    state_d = IDLE;
`ifdef DMEM_CLEAR_ON_RESET_EN
      CLR: begin
        we    = 1'b1;
        widx  = clr_q;
        wdata = '0;
        clr_d = clr_q + 1'b1;
        if (clr_q == LAST_IDX) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST_STATE;
      addr_q  <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
`ifdef DMEM_CLEAR_ON_RESET_EN
      clr_q   <= clr_d;
`endif
    end
  end

  // Array has no reset; a reset edge blocks any write so in-flight requests are aborted.
  always_ff @(posedge clk) begin
    if (!reset && we) mem_q[widx] <= wdata;
  end

  assign mem_data_in = rdata_q;
  assign mem_ready   = (state_q == RRESP) || (state_q == WACK);
  assign addr_fault  = mem_ready & fault_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_unit.sv
// Randomized self-checking bench for data_mem_unit (default build, DEPTH=1024).
module tb_data_mem_unit;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] mem_address;
  logic [18:0] mem_data_out;
  logic        mem_write;
  logic        mem_read;
  logic [18:0] mem_data_in;
  logic        mem_ready;
  logic        addr_fault;
  logic        busy;

  data_mem_unit #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_address  (mem_address),
    .mem_data_out (mem_data_out),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_data_in  (mem_data_in),
    .mem_ready    (mem_ready),
    .addr_fault   (addr_fault),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [18:0] model [DEPTH];
  logic [18:0] last_rd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [18:0] exp_rd(input logic [18:0] a);
    return (int'(a) < DEPTH) ? model[a] : 19'h0;
  endfunction

  // All tasks start and end at 1 time unit after a rising edge with the DUT idle.
  task automatic do_write(input logic [18:0] a, input logic [18:0] d, input logic also_rd);
    mem_address = a; mem_data_out = d; mem_write = 1'b1; mem_read = also_rd;
    @(posedge clk); #1;
    mem_write = 1'b0; mem_read = 1'b0;
    check("wr_ready", mem_ready, 1);
    check("wr_fault", addr_fault, (int'(a) >= DEPTH) ? 1 : 0);
    check("wr_busy", busy, 1);
    check("wr_hold_rdata", mem_data_in, last_rd);
    if (int'(a) < DEPTH) model[a] = d;
    @(posedge clk); #1;
    check("wr_ready_clr", mem_ready, 0);
    check("wr_fault_clr", addr_fault, 0);
    check("wr_idle", busy, 0);
  endtask

  task automatic do_read(input logic [18:0] a);
    mem_address = a; mem_read = 1'b1;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_address = 19'($urandom);
    check("rd_ready_n1", mem_ready, 0);
    check("rd_busy_n1", busy, 1);
    @(posedge clk); #1;
    check("rd_ready", mem_ready, 1);
    check("rd_data", mem_data_in, exp_rd(a));
    check("rd_fault", addr_fault, (int'(a) >= DEPTH) ? 1 : 0);
    last_rd = exp_rd(a);
    @(posedge clk); #1;
    check("rd_ready_clr", mem_ready, 0);
    check("rd_fault_clr", addr_fault, 0);
    check("rd_idle", busy, 0);
    check("rd_hold", mem_data_in, last_rd);
  endtask

  function automatic logic [18:0] pick_addr();
    int unsigned s = $urandom_range(0, 3);
    if (s < 2) return 19'($urandom_range(0, DEPTH - 1));
    if (s == 2) return 19'($urandom_range(DEPTH - 2, DEPTH + 1));
    return 19'($urandom);
  endfunction

  initial begin
    reset = 1'b1; mem_address = '0; mem_data_out = '0; mem_write = 1'b0; mem_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", mem_ready, 0);
    check("rst_fault", addr_fault, 0);
    check("rst_data", mem_data_in, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) do_write(19'(i), 19'($urandom), 1'b0);

    // Basic write/read, write-wins, out-of-range handling.
    do_write(19'd1, 19'h0000F, 1'b0);
    do_read(19'd1);
    do_write(19'd2, 19'h7FFF0, 1'b1);
    do_read(19'd2);
    do_read(19'd1);
    do_read(19'd1024);
    do_write(19'd1024, 19'h12345, 1'b0);
    do_read(19'd0);
    do_read(19'd1023);
    do_read(19'h7FFFF);

    // Reset one cycle after a read is accepted: aborted, no pulse, contents kept.
    mem_address = 19'd1; mem_read = 1'b1;
    @(posedge clk); #1;
    mem_read = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", mem_ready, 0);
    check("abort_data", mem_data_in, 0);
    check("abort_fault", addr_fault, 0);
    check("abort_busy", busy, 0);
    last_rd = '0;
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_no_pulse", mem_ready, 0);
    do_read(19'd1);

    // mem_read toggled while in RD/RRESP produces no extra response.
    mem_address = 19'd2; mem_read = 1'b1;
    @(posedge clk); #1;
    mem_read = 1'b1;
    @(posedge clk); #1;
    check("tog_ready", mem_ready, 1);
    check("tog_data", mem_data_in, model[2]);
    last_rd = model[2];
    mem_read = 1'b0;
    @(posedge clk); #1;
    check("tog_idle", busy, 0);
    @(posedge clk); #1;
    check("tog_no_extra", mem_ready, 0);
    check("tog_still_idle", busy, 0);

    // Held read: one response every 3 cycles.
    mem_address = 19'd1; mem_read = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      check("hold_rd_ready", mem_ready, (i % 3 == 1) ? 1 : 0);
      if (i % 3 == 1) check("hold_rd_data", mem_data_in, model[1]);
    end
    mem_read = 1'b0; last_rd = model[1];
    @(posedge clk); #1;
    check("hold_rd_end", busy, 0);

    // Held write: one ack every 2 cycles.
    mem_address = 19'd7; mem_data_out = 19'h2AAAA; mem_write = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("hold_wr_ready", mem_ready, (i % 2 == 0) ? 1 : 0);
    end
    mem_write = 1'b0; model[7] = 19'h2AAAA;
    do_read(19'd7);

    // Randomized mix against the array model.
    for (int i = 0; i < 300; i++) begin
      logic [18:0] a;
      a = pick_addr();
      case ($urandom_range(0, 3))
        0:       do_write(a, 19'($urandom), 1'b0);
        1:       do_write(a, 19'($urandom), 1'b1);
        default: do_read(a);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 Parameter DEPTH, default 1024, is the number of 19-bit data words; it SHALL be a power of two from 2 to 2^19.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mem_address  input  19  word address from the CPU.
REQ-005 mem_data_out  input  19  store data from the CPU.
REQ-006 mem_write  input  1  store request.
REQ-007 mem_read  input  1  load request.
REQ-008 mem_data_in  output  19  load data returned to the CPU.
REQ-009 mem_ready  output  1  one-cycle completion pulse for the accepted request.
REQ-010 addr_fault  output  1  qualified by mem_ready: the completed access had mem_address >= DEPTH.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have these states: IDLE, RD, RRESP, WACK and CLR, where CLR is present only under REQ-029.
REQ-013 Requests SHALL be sampled only in IDLE; mem_read and mem_write in any other state SHALL be ignored.
REQ-014 If mem_read and mem_write are both high in IDLE, the write SHALL win and the read SHALL be dropped.
REQ-015 Write accepted at edge N: in-range data SHALL be stored at edge N, mem_ready=1 for the cycle after edge N, and the state SHALL be WACK then IDLE at edge N+1.
REQ-016 Read accepted at edge N: the address SHALL be latched and the state SHALL go to RD; at edge N+1 mem_data_in SHALL be loaded, mem_ready=1 and the state SHALL go to RRESP; at edge N+2 mem_ready SHALL clear and the state SHALL return to IDLE.
REQ-017 Read latency SHALL be 2 edges and write latency 1 edge; throughput SHALL be at most one request per 2 cycles for writes and one per 3 cycles for reads.
REQ-018 mem_data_in SHALL hold its last loaded value until the next read completes.
REQ-019 Read-after-write to the same address SHALL return the newly written data.
REQ-020 An out-of-range write SHALL leave the array unchanged and assert addr_fault together with mem_ready.
REQ-021 An out-of-range read SHALL load mem_data_in=0 and assert addr_fault together with mem_ready.
REQ-022 addr_fault SHALL be 0 whenever mem_ready is 0.
REQ-023 Index SHALL be mem_address[log2(DEPTH)-1:0]; range check SHALL use all 19 bits; no wrap-around.
REQ-024 A request still held high when the FSM returns to IDLE SHALL be accepted as a new request; the CPU drops its request on mem_ready.

Reset
REQ-025 When reset is high at an edge: mem_data_in=0, mem_ready=0, addr_fault=0, and the state SHALL become IDLE, or CLR under REQ-029.
REQ-026 Reset SHALL take priority over all requests; a read or write in flight SHALL be aborted with no mem_ready pulse.
REQ-027 A write already committed at an earlier edge SHALL remain in the array after reset unless REQ-029 applies.
REQ-028 busy SHALL be 0 after reset, except in the CLR state.

Configuration
REQ-029 With macro DMEM_CLEAR_ON_RESET_EN defined: after reset, state CLR SHALL write 0 to addresses 0..DEPTH-1, one per cycle, for DEPTH cycles, with busy=1, and requests SHALL be ignored; the state SHALL then be IDLE. Reset during CLR SHALL restart the clear at address 0.
REQ-030 With DMEM_CLEAR_ON_RESET_EN undefined: there SHALL be no CLR state, array contents SHALL be retained across reset, and the block SHALL accept requests at the first edge after reset deasserts.

Verification
REQ-031 Write 19'h0000F to address 1, then read address 1: mem_ready pulses 1 cycle after the write; for the read, mem_ready=1 and mem_data_in=19'h0000F 2 edges after acceptance; addr_fault=0.
REQ-032 Write 19'h7FFF0 to address 2 with mem_read also high: only a write occurs (1-cycle ack); a subsequent read of address 2 returns 19'h7FFF0 and address 1 still returns 19'h0000F.
REQ-033 Read address 1024 with DEPTH=1024: mem_data_in=0 and addr_fault=1 with mem_ready. Write 19'h12345 to address 1024, then read address 0: address 0 is unchanged.
REQ-034 Assert reset the cycle after a read is accepted: no mem_ready pulse and outputs are 0. The next read of address 1 returns 19'h0000F when the macro is undefined.
REQ-035 Toggle mem_read in RD/RRESP: no extra response. Hold mem_read high continuously: one response per 3 cycles.
REQ-036 With DMEM_CLEAR_ON_RESET_EN defined and DEPTH=16: busy=1 for 16 cycles after reset, requests are ignored meanwhile, and every address then reads 0.
